// File: rtl/rcn_pkg.sv
// rcn_pkg: shared RCN ring packet layout and timer register map.
// Latency: n/a (constants and a pure byte-merge helper).
// Backpressure: n/a; the ring has no stall, every node forwards each cycle.
package rcn_pkg;

    localparam int RCN_W       = 69;
    localparam int RCN_VALID   = 68;
    localparam int RCN_REQ     = 67;
    localparam int RCN_WR      = 66;
    localparam int RCN_ID_HI   = 65;
    localparam int RCN_ID_LO   = 60;
    localparam int RCN_MASK_HI = 59;
    localparam int RCN_MASK_LO = 56;
    localparam int RCN_ADDR_HI = 55;   // word address, addr[23:2]
    localparam int RCN_ADDR_LO = 34;
    localparam int RCN_SEQ_HI  = 33;
    localparam int RCN_SEQ_LO  = 32;
    localparam int RCN_DATA_HI = 31;
    localparam int RCN_DATA_LO = 0;

    // Timer register word offsets within the 16-byte window
    localparam logic [1:0] TMR_COUNT   = 2'd0;
    localparam logic [1:0] TMR_COMPARE = 2'd1;
    localparam logic [1:0] TMR_CTRL    = 2'd2;
    localparam logic [1:0] TMR_STATUS  = 2'd3;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_PERIODIC    = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_PRESCALE_LO = 8;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_OVF   = 1;

    // Replace the byte lanes selected by mask with the matching lanes of wdata.
    function automatic logic [31:0] rcn_apply_mask(input logic [31:0] old,
                                                   input logic [31:0] wdata,
                                                   input logic [3:0]  mask);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rcn_slave_port.sv
// rcn_slave_port: ring register stage that turns hits in a 16-byte window into a cs/wr/addr/mask/wdata/rdata access.
// Latency: 1 cycle for every packet; the access happens in the cycle the packet arrives, the response leaves next cycle.
// Backpressure: none; rdata_i must be valid combinationally in the same cycle as cs_o.
module rcn_slave_port
    import rcn_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE = 24'hFFFFA0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RCN_W-1:0] rcn_in_i,
    output logic [RCN_W-1:0] rcn_out_o,
    output logic             cs_o,
    output logic             wr_o,
    output logic [1:0]       addr_o,    // word offset inside the window
    output logic [3:0]       mask_o,
    output logic [31:0]      wdata_o,
    input  logic [31:0]      rdata_i
);

    logic             hit;
    logic [RCN_W-1:0] rsp;
    logic [RCN_W-1:0] rcn_out_q;

    assign hit = rcn_in_i[RCN_VALID] & rcn_in_i[RCN_REQ] &
                 (rcn_in_i[RCN_ADDR_HI:RCN_ADDR_LO+2] == ADDR_BASE[23:4]);

    assign cs_o    = hit;
    assign wr_o    = rcn_in_i[RCN_WR];
    assign addr_o  = rcn_in_i[RCN_ADDR_LO+1:RCN_ADDR_LO];
    assign mask_o  = rcn_in_i[RCN_MASK_HI:RCN_MASK_LO];
    assign wdata_o = rcn_in_i[RCN_DATA_HI:RCN_DATA_LO];

    // Hits become responses in place; writes echo their own data.
    always_comb begin
        rsp = rcn_in_i;
        if (hit) begin
            rsp[RCN_REQ] = 1'b0;
            if (!rcn_in_i[RCN_WR]) rsp[RCN_DATA_HI:RCN_DATA_LO] = rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcn_out_q <= '0;
        else        rcn_out_q <= rsp;
    end

    assign rcn_out_o = rcn_out_q;

endmodule

// File: rtl/rcn_timer.sv
// rcn_timer: RCN ring slave with a 32-bit up-counter, compare match (tick_req pulse, irq level) and overflow flag.
// Latency: 1 cycle ring pass-through for all packets; tick_req/irq registered, 1 cycle after the matching tick.
// Backpressure: none (ring forwards every cycle). Build option RCN_TIMER_PRESCALE_EN adds CTRL[15:8] prescaler.
// Ports: clk, rst_n, rcn_in/rcn_out (69-bit ring), tick_req (match pulse), irq (STATUS.MATCH & CTRL.IRQ_EN).
module rcn_timer
    import rcn_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE  = 24'hFFFFA0,
    parameter int          PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RCN_W-1:0] rcn_in,
    output logic [RCN_W-1:0] rcn_out,
    output logic             tick_req,
    output logic             irq
);

    logic        cs, wr;
    logic [1:0]  addr;
    logic [3:0]  mask;
    logic [31:0] wdata, rdata;

    rcn_slave_port #(.ADDR_BASE(ADDR_BASE)) u_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .rcn_in_i (rcn_in),
        .rcn_out_o(rcn_out),
        .cs_o     (cs),
        .wr_o     (wr),
        .addr_o   (addr),
        .mask_o   (mask),
        .wdata_o  (wdata),
        .rdata_i  (rdata)
    );

    logic [31:0]           count_q, count_d, compare_q, compare_d;
    logic                  en_q, en_d, periodic_q, periodic_d, irq_en_q, irq_en_d;
    logic                  match_q, match_d, ovf_q, ovf_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d, prescale_cfg;
    logic                  tick_req_q, irq_q;
    logic                  wr_count, wr_compare, wr_ctrl, wr_status, clr;
    logic                  tick, match_hit, reload, wrap;

`ifdef RCN_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    assign prescale_cfg = prescale_q;
`else
    // Terminal count pinned at 0: the prescaler never leaves 0, so every enabled clock ticks.
    assign prescale_cfg = '0;
`endif

    assign wr_count   = cs & wr & (addr == TMR_COUNT);
    assign wr_compare = cs & wr & (addr == TMR_COMPARE);
    assign wr_ctrl    = cs & wr & (addr == TMR_CTRL);
    assign wr_status  = cs & wr & (addr == TMR_STATUS);
    assign clr        = wr_status & mask[0];

    assign tick      = en_q & (presc_q == prescale_cfg);
    // A software COUNT write owns the cycle: no match or wrap is evaluated.
    assign match_hit = tick & ~wr_count & (count_q == compare_q);
    assign reload    = match_hit & periodic_q;
    assign wrap      = tick & ~wr_count & ~reload & (count_q == 32'hFFFF_FFFF);

    // Reads see pre-increment state.
    always_comb begin
        rdata = '0;
        case (addr)
            TMR_COUNT:   rdata = count_q;
            TMR_COMPARE: rdata = compare_q;
            TMR_CTRL: begin
                rdata[CTRL_EN]       = en_q;
                rdata[CTRL_PERIODIC] = periodic_q;
                rdata[CTRL_IRQ_EN]   = irq_en_q;
`ifdef RCN_TIMER_PRESCALE_EN
                rdata[CTRL_PRESCALE_LO +: PRESCALE_W] = prescale_q;
`endif
            end
            default: begin
                rdata[STATUS_MATCH] = match_q;
                rdata[STATUS_OVF]   = ovf_q;
            end
        endcase
    end

    always_comb begin
        presc_d = (!en_q || tick) ? '0 : presc_q + PRESCALE_W'(1);

        count_d = count_q;
        if (wr_count)  count_d = rcn_apply_mask(count_q, wdata, mask);
        else if (reload) count_d = '0;
        else if (tick) count_d = count_q + 32'd1;

        compare_d = wr_compare ? rcn_apply_mask(compare_q, wdata, mask) : compare_q;

        en_d       = en_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        if (wr_ctrl && mask[0]) begin
            en_d       = wdata[CTRL_EN];
            periodic_d = wdata[CTRL_PERIODIC];
            irq_en_d   = wdata[CTRL_IRQ_EN];
        end
`ifdef RCN_TIMER_PRESCALE_EN
        prescale_d = prescale_q;
        if (wr_ctrl && mask[1]) prescale_d = wdata[CTRL_PRESCALE_LO +: PRESCALE_W];
`endif

        // Hardware set beats a same-cycle W1C.
        match_d = match_hit | (match_q & ~(clr & wdata[STATUS_MATCH]));
        ovf_d   = wrap      | (ovf_q   & ~(clr & wdata[STATUS_OVF]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            tick_req_q <= 1'b0;
            irq_q      <= 1'b0;
`ifdef RCN_TIMER_PRESCALE_EN
            prescale_q <= '0;
`endif
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            tick_req_q <= match_hit;
            irq_q      <= match_d & irq_en_d;
`ifdef RCN_TIMER_PRESCALE_EN
            prescale_q <= prescale_d;
`endif
        end
    end

    assign tick_req = tick_req_q;
    assign irq      = irq_q;

endmodule
